// File: rtl/cmd_seq.sv
// cmd_seq: buffered host-command sequencer for the maze robot.
// Queued commands run one at a time against the engines, each guarded by a watchdog.
module cmd_seq #(
  parameter int unsigned CMD_W   = 16,
  parameter int unsigned HDNG_W  = 12,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TMO_CYC = 1_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CMD_W-1:0]         cmd,
  input  logic                     cmd_rdy,
  output logic                     clr_cmd_rdy,
  input  logic                     cal_done,
  input  logic                     mv_cmplt,
  input  logic                     sol_cmplt,
  output logic                     strt_cal,
  output logic                     in_cal,
  output logic                     strt_hdng,
  output logic                     strt_mv,
  output logic [HDNG_W-1:0]        dsrd_hdng,
  output logic                     stp_lft,
  output logic                     stp_rght,
  output logic                     cmd_md,
  output logic                     send_resp,
  output logic [7:0]               resp,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     fifo_full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned ENT_W = 3 + HDNG_W;
  localparam int unsigned TMO_W = $clog2(TMO_CYC);

  localparam logic [2:0] OpCal   = 3'b000;
  localparam logic [2:0] OpHdng  = 3'b001;
  localparam logic [2:0] OpMove  = 3'b010;
  localparam logic [2:0] OpSolv  = 3'b011;
  localparam logic [2:0] OpFlush = 3'b111;

  localparam logic [7:0] RespAck   = 8'hA5;
  localparam logic [7:0] RespNak   = 8'h0F;
  localparam logic [7:0] RespTmo   = 8'hEE;
  localparam logic [7:0] RespFlush = 8'hAB;

  typedef enum logic [2:0] {StIdle, StCali, StHdng, StMove, StSolv} state_t;

  state_t             r_state;
  logic [TMO_W-1:0]   r_tmo;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [ENT_W-1:0]   r_mem [DEPTH];

  logic [2:0]         w_cmd_op;
  logic               w_flush;
  logic               w_push;
  logic               w_pop;
  logic [ENT_W-1:0]   w_head;
  logic [2:0]         w_head_op;
  logic               w_done;
  logic               w_tmo_hit;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Entries keep only the opcode and heading field; stop bits live in the heading LSBs.
  assign w_cmd_op    = cmd[CMD_W-1 -: 3];
  assign clr_cmd_rdy = cmd_rdy & ~fifo_full;
  assign w_flush     = clr_cmd_rdy & (w_cmd_op == OpFlush);
  assign w_push      = clr_cmd_rdy & ~w_flush;
  assign w_pop       = (r_state == StIdle) & (fifo_cnt != '0) & ~w_flush;
  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_op   = w_head[ENT_W-1 -: 3];
  assign w_cnt_nxt   = fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
  assign w_tmo_hit   = (r_tmo == TMO_W'(TMO_CYC - 1));
  assign w_done      = ((r_state == StCali) & cal_done) |
                       (((r_state == StHdng) | (r_state == StMove)) & mv_cmplt) |
                       ((r_state == StSolv) & sol_cmplt);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_cmd_op, cmd[HDNG_W-1:0]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      fifo_cnt  <= '0;
      fifo_full <= 1'b0;
    end else if (w_flush) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      fifo_cnt  <= '0;
      fifo_full <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      fifo_cnt  <= w_cnt_nxt;
      fifo_full <= (w_cnt_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_tmo     <= '0;
      strt_cal  <= 1'b0;
      strt_hdng <= 1'b0;
      strt_mv   <= 1'b0;
      in_cal    <= 1'b0;
      dsrd_hdng <= '0;
      stp_lft   <= 1'b0;
      stp_rght  <= 1'b0;
      cmd_md    <= 1'b1;
      send_resp <= 1'b0;
      resp      <= 8'h00;
      busy      <= 1'b0;
    end else begin
      strt_cal  <= 1'b0;
      strt_hdng <= 1'b0;
      strt_mv   <= 1'b0;
      send_resp <= 1'b0;
      if (w_flush) begin
        // Flush outranks any done, timeout or pop landing in the same cycle.
        r_state   <= StIdle;
        r_tmo     <= '0;
        in_cal    <= 1'b0;
        cmd_md    <= 1'b1;
        busy      <= 1'b0;
        send_resp <= 1'b1;
        resp      <= RespFlush;
      end else begin
        case (r_state)
          StIdle: begin
            r_tmo <= '0;
            if (w_pop) begin
              unique case (w_head_op)
                OpCal: begin
                  r_state  <= StCali;
                  strt_cal <= 1'b1;
                  in_cal   <= 1'b1;
                  busy     <= 1'b1;
                end
                OpHdng: begin
                  r_state   <= StHdng;
                  strt_hdng <= 1'b1;
                  dsrd_hdng <= w_head[HDNG_W-1:0];
                  busy      <= 1'b1;
                end
                OpMove: begin
                  r_state  <= StMove;
                  strt_mv  <= 1'b1;
                  stp_lft  <= w_head[1];
                  stp_rght <= w_head[0];
                  busy     <= 1'b1;
                end
                OpSolv: begin
                  r_state <= StSolv;
                  cmd_md  <= 1'b0;
                  busy    <= 1'b1;
                end
                default: begin
                  send_resp <= 1'b1;
                  resp      <= RespNak;
                end
              endcase
            end
          end
          default: begin
            if (w_done || w_tmo_hit) begin
              r_state   <= StIdle;
              in_cal    <= 1'b0;
              cmd_md    <= 1'b1;
              busy      <= 1'b0;
              send_resp <= 1'b1;
              resp      <= w_done ? RespAck : RespTmo;
            end else begin
              r_tmo <= r_tmo + TMO_W'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_seq.sv
// Self-checking bench for cmd_seq: directed steps with response and start scoreboards.
module tb_cmd_seq;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TMO   = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy;
  logic        cal_done;
  logic        mv_cmplt;
  logic        sol_cmplt;
  logic        strt_cal;
  logic        in_cal;
  logic        strt_hdng;
  logic        strt_mv;
  logic [11:0] dsrd_hdng;
  logic        stp_lft;
  logic        stp_rght;
  logic        cmd_md;
  logic        send_resp;
  logic [7:0]  resp;
  logic        busy;
  logic [2:0]  fifo_cnt;
  logic        fifo_full;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  exp_resp [$];
  logic [15:0] exp_start [$];
  logic        prev_strt = 1'b0;
  logic        prev_sr   = 1'b0;
  logic        prev_md   = 1'b1;
  bit          found;

  cmd_seq #(
    .CMD_W   (16),
    .HDNG_W  (12),
    .DEPTH   (DEPTH),
    .TMO_CYC (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .cal_done    (cal_done),
    .mv_cmplt    (mv_cmplt),
    .sol_cmplt   (sol_cmplt),
    .strt_cal    (strt_cal),
    .in_cal      (in_cal),
    .strt_hdng   (strt_hdng),
    .strt_mv     (strt_mv),
    .dsrd_hdng   (dsrd_hdng),
    .stp_lft     (stp_lft),
    .stp_rght    (stp_rght),
    .cmd_md      (cmd_md),
    .send_resp   (send_resp),
    .resp        (resp),
    .busy        (busy),
    .fifo_cnt    (fifo_cnt),
    .fifo_full   (fifo_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start signature: kind in [15:14], then the fields that must be valid with that start.
  function automatic logic [15:0] start_of(input logic [15:0] c);
    case (c[15:13])
      3'd0:    return {2'd1, 1'b1, 1'b0, 12'd0};
      3'd1:    return {2'd2, 2'b00, c[11:0]};
      3'd2:    return {2'd3, c[1], c[0], 12'd0};
      default: return 16'h3FFF;
    endcase
  endfunction

  function automatic logic [15:0] start_seen();
    if ($countones({strt_cal, strt_hdng, strt_mv}) > 1) return 16'hFFFF;
    if (strt_cal)  return {2'd1, in_cal, 1'b0, 12'd0};
    if (strt_hdng) return {2'd2, 2'b00, dsrd_hdng};
    if (strt_mv)   return {2'd3, stp_lft, stp_rght, 12'd0};
    return 16'h3FFF;
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      prev_strt <= 1'b0;
      prev_sr   <= 1'b0;
      prev_md   <= 1'b1;
    end else begin
      if (strt_cal || strt_hdng || strt_mv || (prev_md && !cmd_md)) begin
        chk("start_pending", 32'(exp_start.size() != 0), 1);
        if (exp_start.size() != 0) chk("start_fields", 32'(start_seen()),
                                       32'(exp_start.pop_front()));
      end
      if (strt_cal || strt_hdng || strt_mv) chk("strt_width", 32'(prev_strt), 0);
      if (send_resp) begin
        chk("resp_pending", 32'(exp_resp.size() != 0), 1);
        if (exp_resp.size() != 0) chk("resp_code", 32'(resp), 32'(exp_resp.pop_front()));
        chk("resp_width", 32'(prev_sr), 0);
      end
      prev_strt <= strt_cal | strt_hdng | strt_mv;
      prev_sr   <= send_resp;
      prev_md   <= cmd_md;
    end
  end

  task automatic send(input logic [15:0] c, input bit expect_start);
    cmd     = c;
    cmd_rdy = 1'b1;
    if (expect_start) exp_start.push_back(start_of(c));
    #1 chk("accept", 32'(clr_cmd_rdy), 1);
    @(negedge clk);
    cmd_rdy = 1'b0;
  endtask

  task automatic pulse(input int which, input logic [7:0] r);
    exp_resp.push_back(r);
    case (which)
      0:       cal_done  = 1'b1;
      1:       mv_cmplt  = 1'b1;
      default: sol_cmplt = 1'b1;
    endcase
    @(negedge clk);
    cal_done  = 1'b0;
    mv_cmplt  = 1'b0;
    sol_cmplt = 1'b0;
  endtask

  function automatic logic cond(input int which);
    case (which)
      0:       return busy;
      1:       return in_cal;
      2:       return strt_mv;
      default: return clr_cmd_rdy;
    endcase
  endfunction

  task automatic wait_for(input string tag, input int which, input int max);
    bit hit = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (cond(which)) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk(tag, 32'(hit), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    cmd = '0; cmd_rdy = 1'b0; cal_done = 1'b0; mv_cmplt = 1'b0; sol_cmplt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_md", 32'(cmd_md), 1);
    chk("rst_fifo_cnt", 32'(fifo_cnt), 0);
    chk("rst_fifo_full", 32'(fifo_full), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_resp", 32'(resp), 0);
    chk("rst_outs", 32'({send_resp, in_cal, strt_cal, strt_hdng, strt_mv, stp_lft, stp_rght}), 0);
    chk("rst_dsrd", 32'(dsrd_hdng), 0);
    #2 rst = 1'b0;
    @(negedge clk);

    // Single HDNG command, latency and completion.
    send(16'h2155, 1'b1);
    chk("cnt_after_push", 32'(fifo_cnt), 1);
    @(negedge clk);
    chk("hdng_strt", 32'(strt_hdng), 1);
    chk("hdng_busy", 32'(busy), 1);
    chk("hdng_dsrd", 32'(dsrd_hdng), 32'h155);
    pulse(1, 8'hA5);
    chk("hdng_idle", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("resp_hold", 32'(resp), 32'hA5);
    chk("dsrd_hold", 32'(dsrd_hdng), 32'h155);

    // CAL, MOVE, SOLV back-to-back, order preserved.
    send(16'h0000, 1'b1);
    send(16'h4003, 1'b1);
    send(16'h6000, 1'b1);
    wait_for("cal_run", 1, 10);
    pulse(0, 8'hA5);
    chk("cal_in_cal_drop", 32'(in_cal), 0);
    wait_for("mv_run", 0, 10);
    pulse(1, 8'hA5);
    wait_for("solv_run", 0, 10);
    chk("solv_cmd_md", 32'(cmd_md), 0);
    pulse(2, 8'hA5);
    chk("solv_md_back", 32'(cmd_md), 1);
    chk("solv_idle", 32'(busy), 0);

    // Fill the FIFO behind a stalled CAL; fifth command is held until a pop frees a slot.
    send(16'h0000, 1'b1);
    send(16'h2001, 1'b1);
    send(16'h2002, 1'b1);
    send(16'h2003, 1'b1);
    send(16'h2004, 1'b1);
    chk("fill_full", 32'(fifo_full), 1);
    chk("fill_cnt", 32'(fifo_cnt), DEPTH);
    cmd = 16'h4001; cmd_rdy = 1'b1;
    exp_start.push_back(start_of(16'h4001));
    #1 chk("full_no_accept", 32'(clr_cmd_rdy), 0);
    @(negedge clk);
    chk("full_still_held", 32'(clr_cmd_rdy), 0);
    pulse(0, 8'hA5);
    wait_for("accept5", 3, 5);
    @(negedge clk);
    cmd_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wait_for("drain_run", 0, 10);
      pulse(1, 8'hA5);
    end
    chk("drain_cnt", 32'(fifo_cnt), 0);

    // Illegal opcode: NAK, no start, never busy.
    exp_resp.push_back(8'h0F);
    send(16'h8000, 1'b0);
    chk("nak_busy0", 32'(busy), 0);
    @(negedge clk);
    chk("nak_busy1", 32'(busy), 0);
    chk("nak_cnt", 32'(fifo_cnt), 0);
    @(negedge clk);
    chk("nak_busy2", 32'(busy), 0);

    // Watchdog on a MOVE that never completes.
    exp_resp.push_back(8'hEE);
    send(16'h4002, 1'b1);
    wait_for("tmo_strt", 2, 5);
    found = 1'b0;
    for (int k = 1; k <= 3 * TMO; k++) begin
      @(negedge clk);
      if (send_resp) begin
        chk("tmo_latency", 32'(k), TMO);
        found = 1'b1;
        break;
      end
    end
    chk("tmo_seen", 32'(found), 1);
    chk("tmo_idle", 32'(busy), 0);

    // Flush during a MOVE with three queued, colliding with mv_cmplt.
    send(16'h4003, 1'b1);
    send(16'h2010, 1'b0);
    send(16'h2020, 1'b0);
    send(16'h2030, 1'b0);
    chk("pre_flush_cnt", 32'(fifo_cnt), 3);
    chk("pre_flush_busy", 32'(busy), 1);
    cmd = 16'hE000; cmd_rdy = 1'b1; mv_cmplt = 1'b1;
    exp_resp.push_back(8'hAB);
    #1 chk("flush_accept", 32'(clr_cmd_rdy), 1);
    @(negedge clk);
    cmd_rdy = 1'b0; mv_cmplt = 1'b0;
    chk("flush_cnt", 32'(fifo_cnt), 0);
    chk("flush_busy", 32'(busy), 0);
    chk("flush_cmd_md", 32'(cmd_md), 1);
    repeat (TMO + 4) @(negedge clk);

    // Reset mid-command: immediate return to reset values, no response.
    send(16'h0000, 1'b1);
    wait_for("rst_cal_run", 1, 10);
    #2 rst = 1'b1;
    #1;
    chk("midrst_in_cal", 32'(in_cal), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_resp", 32'(resp), 0);
    chk("midrst_cmd_md", 32'(cmd_md), 1);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (TMO + 4) @(negedge clk);

    chk("resp_queue_empty", 32'(exp_resp.size()), 0);
    chk("start_queue_empty", 32'(exp_start.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cmd_seq.md
# cmd_seq

Queued command sequencer for the maze robot: accepts 16-bit host commands from the UART wrapper, buffers up to DEPTH of them in an internal FIFO, and executes them one at a time against the calibration, heading, move and solve engines. It is the parametrised successor of the single-command processor. It adds:
- command buffering,
- a flush opcode,
- a per-command watchdog timeout,
- a coded response byte, so the host can tell success from rejection, abort or timeout.

## Interface
Parameters:
- CMD_W, 16, command width; opcode is cmd[CMD_W-1:CMD_W-3]
- HDNG_W, 12, heading field width; heading is cmd[HDNG_W-1:0], HDNG_W <= CMD_W-3
- DEPTH, 4, FIFO entries, power of two, >= 2
- TMO_CYC, 1_000_000, watchdog limit in clk cycles per command, >= 2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd  in  CMD_W  command word, valid while cmd_rdy high
- cmd_rdy  in  1  command available from UART wrapper
- clr_cmd_rdy  out  1  command accepted (consumes cmd_rdy)
- cal_done  in  1  calibration complete
- mv_cmplt  in  1  heading/move complete
- sol_cmplt  in  1  maze solve complete
- strt_cal  out  1  one-cycle start to calibration
- in_cal  out  1  high throughout calibration
- strt_hdng  out  1  one-cycle start heading change
- strt_mv  out  1  one-cycle start move
- dsrd_hdng  out  HDNG_W  desired heading
- stp_lft  out  1  move stops at left opening (cmd[1])
- stp_rght  out  1  move stops at right opening (cmd[0])
- cmd_md  out  1  1 = command mode, 0 = autonomous solve
- send_resp  out  1  one-cycle response strobe to UART wrapper
- resp  out  8  response code, valid when send_resp high
- busy  out  1  execution FSM not in IDLE
- fifo_cnt  out  $clog2(DEPTH)+1  queued entries
- fifo_full  out  1  fifo_cnt == DEPTH

## Operation
Opcodes:
- 000 = CAL
- 001 = HDNG
- 010 = MOVE
- 011 = SOLV
- 111 = FLUSH
- 100–110 = illegal

Intake (combinational accept):
- clr_cmd_rdy = cmd_rdy & ~fifo_full.
- A non-FLUSH cmd is pushed on that edge; illegal opcodes are pushed too.
- When full, nothing is accepted; cmd_rdy stays pending.
- FLUSH is never queued. Accepting it:
  - empties the FIFO;
  - forces the FSM to IDLE and drops in_cal;
  - clears the timeout counter;
  - issues send_resp with resp=8'hAB.

Execution FSM states: IDLE, CALI, HDNG, MOVE, SOLV.
- IDLE, FIFO non-empty: pop the head and decode it.
  - CAL → CALI, strt_cal.
  - HDNG → HDNG, strt_hdng, dsrd_hdng loaded.
  - MOVE → MOVE, strt_mv, stp_lft/stp_rght loaded.
  - SOLV → SOLV.
  - Illegal → stay IDLE, send_resp with resp=8'h0F (NAK).
- CALI: in_cal=1. On cal_done → IDLE, resp=8'hA5.
- HDNG or MOVE: on mv_cmplt → IDLE, resp=8'hA5.
- SOLV: cmd_md=0. On sol_cmplt → IDLE, resp=8'hA5.
- Done inputs not matching the current state are ignored, including all done inputs in IDLE.

Watchdog:
- A TMO counter is cleared on entry to any busy state and increments every busy cycle.
- When it reaches TMO_CYC-1 without the matching done → IDLE, send_resp, resp=8'hEE.

Field holding: dsrd_hdng, stp_lft and stp_rght hold until the next HDNG/MOVE pop.

Priority within one cycle:
- FLUSH > done > timeout.
- At most one send_resp per cycle.
- An illegal pop and a FLUSH in the same cycle produce only the 8'hAB response.

FIFO pointer rules:
- Push and pop in the same cycle leave fifo_cnt unchanged.
- Pointers wrap modulo DEPTH.

## Timing
All outputs except clr_cmd_rdy are registered.

Reset values (while rst high, asynchronously):
- state IDLE, FIFO empty, fifo_cnt 0, fifo_full 0, busy 0.
- All start pulses 0, send_resp 0, resp 8'h00, in_cal 0.
- dsrd_hdng 0, stp_lft 0, stp_rght 0.
- cmd_md 1.

Latency:
- cmd_rdy in cycle N with FIFO empty and FSM idle: push at end of N, fifo_cnt=1 in N+1, pop at end of N+1.
- In N+2: strt_* high for exactly one cycle, state/busy/in_cal updated, dsrd_hdng and stp_* valid.
- Done input in cycle M: send_resp/resp in M+1, busy low in M+1.
- Next queued command: strt_* in M+2.

Other timing:
- send_resp and all strt_* are exactly one cycle wide.
- resp holds its value until the next response.
- Timeout: send_resp occurs TMO_CYC cycles after the strt pulse if no done arrives.
- rst asserted mid-command: outputs return to reset values immediately and no response is sent.

## Test plan
- After reset: cmd_md=1, fifo_cnt=0, resp=0. Send 16'h2155 (HDNG) → clr_cmd_rdy same cycle; strt_hdng and dsrd_hdng=12'h155 two cycles later. Pulse mv_cmplt → send_resp with resp=A5 next cycle.
- Queue 16'h0000, 16'h4003, 16'h6000 back-to-back, then complete each: strt_cal with in_cal held → A5; strt_mv with stp_lft=1, stp_rght=1 → A5; cmd_md=0 until sol_cmplt → A5. Order is preserved.
- DEPTH=4: fill the FIFO while CALI is stalled, hold cmd_rdy on a 5th command → fifo_full=1, clr_cmd_rdy=0. Pulse cal_done → the 5th command is accepted on the following pop cycle.
- Send 16'h8000 → popped, resp=0F, no strt pulse, busy stays 0.
- TMO_CYC=16, send MOVE, never assert mv_cmplt → resp=EE with send_resp exactly 16 cycles after strt_mv.
- With 3 queued and MOVE running, send 16'hE000 → resp=AB, fifo_cnt=0, busy=0. A mv_cmplt in the same cycle produces no A5.
